// File: rtl/ps2_kbd_pkg.sv
// Scan-code set 2 constants and prefix FSM state encoding shared by the PS/2 key decoder.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_D = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 bytes into held-key levels for Enter, Left and Right arrows.
// Define ALT_WASD_KEYS_EN to let the A and D letter keys also drive LeftEn / RightEn.
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter logic [7:0] ENTER_CODE = SC_ENTER,
  parameter logic [7:0] LEFT_CODE  = SC_LEFT,
  parameter logic [7:0] RIGHT_CODE = SC_RIGHT
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       EnterEn,
  output logic       LeftEn,
  output logic       RightEn,
  output logic [7:0] key_data,
  output logic [1:0] state_dbg
);

  // Handshake: received_data is consumed on every rising edge where
  // received_data_en is high; there is no back-pressure (always ready).

  kbd_state_e state_q, state_nxt;
  logic       enter_q, enter_nxt;
  logic       left_q, left_nxt;
  logic       right_q, right_nxt;
  logic       do_decode, is_make, is_ext;
  logic       byte_is_ext, byte_is_brk;

  assign byte_is_ext = (received_data == SC_EXT);
  assign byte_is_brk = (received_data == SC_BRK);

  always_comb begin
    state_nxt = state_q;
    do_decode = 1'b0;
    is_make   = 1'b0;
    is_ext    = 1'b0;
    if (received_data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_is_ext)      state_nxt = ST_EXT;
          else if (byte_is_brk) state_nxt = ST_BRK;
          else begin
            do_decode = 1'b1;
            is_make   = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_is_brk)      state_nxt = ST_EXT_BRK;
          else if (byte_is_ext) state_nxt = ST_EXT;
          else begin
            do_decode = 1'b1;
            is_make   = 1'b1;
            is_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (byte_is_brk)      state_nxt = ST_BRK;
          else if (byte_is_ext) state_nxt = ST_EXT_BRK;
          else begin
            do_decode = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (byte_is_ext || byte_is_brk) state_nxt = ST_EXT_BRK;
          else begin
            do_decode = 1'b1;
            is_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Each flag only moves on a matching code; anything else leaves it as is.
  always_comb begin
    enter_nxt = enter_q;
    left_nxt  = left_q;
    right_nxt = right_q;
    if (do_decode) begin
      if (!is_ext && received_data == ENTER_CODE) enter_nxt = is_make;
      if (is_ext && received_data == LEFT_CODE)   left_nxt  = is_make;
      if (is_ext && received_data == RIGHT_CODE)  right_nxt = is_make;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      enter_q  <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      key_data <= 8'h00;
    end else begin
      state_q <= state_nxt;
      enter_q <= enter_nxt;
      left_q  <= left_nxt;
      right_q <= right_nxt;
      if (received_data_en) key_data <= received_data;
    end
  end

`ifdef ALT_WASD_KEYS_EN
  // Letter keys are tracked apart from the arrows so releasing one
  // direction source does not drop a flag still held by the other.
  logic key_a_q, key_a_nxt;
  logic key_d_q, key_d_nxt;

  always_comb begin
    key_a_nxt = key_a_q;
    key_d_nxt = key_d_q;
    if (do_decode && !is_ext) begin
      if (received_data == SC_KEY_A) key_a_nxt = is_make;
      if (received_data == SC_KEY_D) key_d_nxt = is_make;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      key_a_q <= 1'b0;
      key_d_q <= 1'b0;
    end else begin
      key_a_q <= key_a_nxt;
      key_d_q <= key_d_nxt;
    end
  end

  assign LeftEn  = left_q | key_a_q;
  assign RightEn = right_q | key_d_q;
`else
  assign LeftEn  = left_q;
  assign RightEn = right_q;
`endif

  assign EnterEn   = enter_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: byte sequences with hand-computed flag, key_data and state results.
module tb_ps2_key_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       enter_en, left_en, right_en;
  logic [7:0] key_data;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_decoder dut (
    .CLOCK_50         (clk),
    .Reset            (rst),
    .received_data    (rx_data),
    .received_data_en (rx_en),
    .EnterEn          (enter_en),
    .LeftEn           (left_en),
    .RightEn          (right_en),
    .key_data         (key_data),
    .state_dbg        (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Driver tasks: inputs change on the falling edge, outputs are sampled there too.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_en   = 1'b1;
    @(negedge clk);
    rx_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held with a simultaneous strobe: reset must win.
    rst     = 1'b1;
    rx_en   = 1'b1;
    rx_data = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    rx_en = 1'b0;
    rst   = 1'b0;
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {enter_en, left_en, right_en});
    end
    n_checks++;
    if (key_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_key got=%h exp=00", key_data);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg);
    end
  endtask

  task automatic test_enter();
    send(8'h5A);
    n_checks++;
    if ({enter_en, left_en, right_en, key_data} !== {3'b100, 8'h5A}) begin
      n_fail++; $display("FAIL enter_make got=%b/%h exp=100/5a", {enter_en, left_en, right_en}, key_data);
    end
    send(8'hF0);
    n_checks++;
    if ({enter_en, key_data, state_dbg} !== {1'b1, 8'hF0, 2'd2}) begin
      n_fail++; $display("FAIL enter_brk_prefix got=%b/%h/%0d exp=1/f0/2", enter_en, key_data, state_dbg);
    end
    send(8'h5A);
    n_checks++;
    if ({enter_en, left_en, right_en, state_dbg} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL enter_break got=%b/%0d exp=000/0", {enter_en, left_en, right_en}, state_dbg);
    end
  endtask

  task automatic test_left();
    send(8'hE0);
    n_checks++;
    if ({key_data, state_dbg} !== {8'hE0, 2'd1}) begin
      n_fail++; $display("FAIL left_ext_prefix got=%h/%0d exp=e0/1", key_data, state_dbg);
    end
    send(8'h6B);
    n_checks++;
    if ({enter_en, left_en, right_en, key_data} !== {3'b010, 8'h6B}) begin
      n_fail++; $display("FAIL left_make got=%b/%h exp=010/6b", {enter_en, left_en, right_en}, key_data);
    end
    send(8'hE0);
    send(8'hF0);
    n_checks++;
    if ({left_en, state_dbg} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL left_ext_brk_prefix got=%b/%0d exp=1/3", left_en, state_dbg);
    end
    send(8'h6B);
    n_checks++;
    if ({enter_en, left_en, right_en, state_dbg} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL left_break got=%b/%0d exp=000/0", {enter_en, left_en, right_en}, state_dbg);
    end
  endtask

  task automatic test_right();
    send(8'hE0); send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b001) begin
      n_fail++; $display("FAIL right_make got=%b exp=001", {enter_en, left_en, right_en});
    end
    send(8'hE0); send(8'hF0); send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en, key_data} !== {3'b000, 8'h74}) begin
      n_fail++; $display("FAIL right_break got=%b/%h exp=000/74", {enter_en, left_en, right_en}, key_data);
    end
  endtask

  task automatic test_multi_key();
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b011) begin
      n_fail++; $display("FAIL multi_left_right got=%b exp=011", {enter_en, left_en, right_en});
    end
    send(8'h5A);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b111) begin
      n_fail++; $display("FAIL multi_all got=%b exp=111", {enter_en, left_en, right_en});
    end
    send(8'hE0); send(8'hF0); send(8'h6B);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b101) begin
      n_fail++; $display("FAIL multi_release_left got=%b exp=101", {enter_en, left_en, right_en});
    end
    send(8'hF0); send(8'h5A);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b001) begin
      n_fail++; $display("FAIL multi_release_enter got=%b exp=001", {enter_en, left_en, right_en});
    end
    send(8'hE0); send(8'hF0); send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b000) begin
      n_fail++; $display("FAIL multi_release_right got=%b exp=000", {enter_en, left_en, right_en});
    end
  endtask

  task automatic test_typematic();
    send(8'h5A); send(8'h5A); send(8'h5A);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b100) begin
      n_fail++; $display("FAIL typematic_hold got=%b exp=100", {enter_en, left_en, right_en});
    end
    send(8'hF0); send(8'h5A);
    send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h6B);
    n_checks++;
    if ({enter_en, left_en, right_en, state_dbg} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL break_not_held got=%b/%0d exp=000/0", {enter_en, left_en, right_en}, state_dbg);
    end
  endtask

  task automatic test_ignored_codes();
    send(8'h6B);
    send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en, state_dbg} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL nonext_arrows got=%b/%0d exp=000/0", {enter_en, left_en, right_en}, state_dbg);
    end
    send(8'hE0); send(8'h5A);
    n_checks++;
    if ({enter_en, left_en, right_en, key_data} !== {3'b000, 8'h5A}) begin
      n_fail++; $display("FAIL ext_enter got=%b/%h exp=000/5a", {enter_en, left_en, right_en}, key_data);
    end
    send(8'h1C);
`ifdef ALT_WASD_KEYS_EN
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b010) begin
      n_fail++; $display("FAIL key_a got=%b exp=010", {enter_en, left_en, right_en});
    end
`else
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b000) begin
      n_fail++; $display("FAIL key_a got=%b exp=000", {enter_en, left_en, right_en});
    end
`endif
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h33);
    n_checks++;
    if ({enter_en, left_en, right_en, state_dbg} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL unknown_ext got=%b/%0d exp=000/0", {enter_en, left_en, right_en}, state_dbg);
    end
  endtask

  task automatic test_prefix_repeat();
    send(8'hE0); send(8'hE0);
    n_checks++;
    if (state_dbg !== 2'd1) begin
      n_fail++; $display("FAIL ext_ext_state got=%0d exp=1", state_dbg);
    end
    send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b001) begin
      n_fail++; $display("FAIL ext_ext_make got=%b exp=001", {enter_en, left_en, right_en});
    end
    send(8'hF0); send(8'hF0);
    n_checks++;
    if (state_dbg !== 2'd2) begin
      n_fail++; $display("FAIL brk_brk_state got=%0d exp=2", state_dbg);
    end
    send(8'hE0); send(8'hF0); send(8'hE0);
    n_checks++;
    if (state_dbg !== 2'd3) begin
      n_fail++; $display("FAIL brk_ext_state got=%0d exp=3", state_dbg);
    end
    send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en, state_dbg} !== {3'b000, 2'd0}) begin
      n_fail++; $display("FAIL brk_ext_break got=%b/%0d exp=000/0", {enter_en, left_en, right_en}, state_dbg);
    end
  endtask

  task automatic test_hold_without_strobe();
    send(8'hE0);
    @(negedge clk); rx_data = 8'hF0;
    @(negedge clk); rx_data = 8'h74;
    @(negedge clk); rx_data = 8'h5A;
    @(negedge clk);
    n_checks++;
    if ({state_dbg, key_data, enter_en, left_en, right_en} !== {2'd1, 8'hE0, 3'b000}) begin
      n_fail++; $display("FAIL idle_hold got=%0d/%h/%b exp=1/e0/000", state_dbg, key_data, {enter_en, left_en, right_en});
    end
    send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en} !== 3'b001) begin
      n_fail++; $display("FAIL hold_then_make got=%b exp=001", {enter_en, left_en, right_en});
    end
  endtask

  task automatic test_reset_mid_sequence();
    // Right is still held from the previous scenario; reset must drop it.
    send(8'h5A);
    send(8'hE0);
    pulse_reset();
    n_checks++;
    if ({enter_en, left_en, right_en, key_data, state_dbg} !== {3'b000, 8'h00, 2'd0}) begin
      n_fail++; $display("FAIL reset_in_ext got=%b/%h/%0d exp=000/00/0", {enter_en, left_en, right_en}, key_data, state_dbg);
    end
    send(8'h74);
    n_checks++;
    if ({enter_en, left_en, right_en, key_data} !== {3'b000, 8'h74}) begin
      n_fail++; $display("FAIL after_reset_74 got=%b/%h exp=000/74", {enter_en, left_en, right_en}, key_data);
    end
  endtask

  initial begin
    rst     = 1'b0;
    rx_en   = 1'b0;
    rx_data = 8'h00;
    test_reset();
    test_enter();
    test_left();
    test_right();
    test_multi_key();
    test_typematic();
    test_ignored_codes();
    test_prefix_repeat();
    test_hold_without_strobe();
    test_reset_mid_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
